// File: rtl/memstage.sv
// Memory stage plus MEM/WB register: issues loads/stores on a req/ack data bus,
// commits NZCV flags and registers the selected write-back value for WB.
module memstage #(
  parameter int WORDSIZE    = 64,
  parameter int REGADDRSIZE = 5,
  parameter int FLAGSIZE    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   nopin,
  input  logic                   memread,
  input  logic                   memwrite,
  input  logic                   setflags,
  input  logic                   regwrite,
  input  logic                   movsel,
  input  logic                   signext,
  input  logic [1:0]             size,
  input  logic [WORDSIZE-1:0]    aluresin,
  input  logic [WORDSIZE-1:0]    movresin,
  input  logic [WORDSIZE-1:0]    readreg2in,
  input  logic [FLAGSIZE-1:0]    flagstosetin,
  input  logic [REGADDRSIZE-1:0] rdin,
  output logic                   stall,
  output logic                   fault,
  output logic [FLAGSIZE-1:0]    flags,
  output logic                   dreq,
  output logic                   dwe,
  output logic [WORDSIZE-1:0]    daddr,
  output logic [WORDSIZE-1:0]    dwdata,
  output logic [1:0]             dsize,
  input  logic                   dack,
  input  logic [WORDSIZE-1:0]    drdata,
  output logic                   nopout,
  output logic                   regwriteout,
  output logic [WORDSIZE-1:0]    wbdata,
  output logic [REGADDRSIZE-1:0] rdout
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic                   dreq_q, dreq_d;
  logic                   dwe_q, dwe_d;
  logic [WORDSIZE-1:0]    daddr_q, daddr_d;
  logic [WORDSIZE-1:0]    dwdata_q, dwdata_d;
  logic [1:0]             dsize_q, dsize_d;
  logic [FLAGSIZE-1:0]    flags_q, flags_d;
  logic                   fault_q, fault_d;
  logic                   nop_q, nop_d;
  logic                   regwrite_q, regwrite_d;
  logic [WORDSIZE-1:0]    wbdata_q, wbdata_d;
  logic [REGADDRSIZE-1:0] rd_q, rd_d;

  logic                   valid, is_mem, is_store, misaligned, complete;
  logic [WORDSIZE-1:0]    load_data, wb_sel;

  always_comb begin
    valid    = ~nopin;
    is_mem   = valid & (memread | memwrite);
    is_store = memwrite & ~memread;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = aluresin[0];
      2'b10:   misaligned = |aluresin[1:0];
      default: misaligned = |aluresin[2:0];
    endcase
  end

  // Read data is right-justified; extension width follows the latched bus size.
  always_comb begin
    case (dsize_q)
      2'b00:   load_data = signext ? {{(WORDSIZE-8){drdata[7]}},   drdata[7:0]}
                                   : {{(WORDSIZE-8){1'b0}},        drdata[7:0]};
      2'b01:   load_data = signext ? {{(WORDSIZE-16){drdata[15]}}, drdata[15:0]}
                                   : {{(WORDSIZE-16){1'b0}},       drdata[15:0]};
      2'b10:   load_data = signext ? {{(WORDSIZE-32){drdata[31]}}, drdata[31:0]}
                                   : {{(WORDSIZE-32){1'b0}},       drdata[31:0]};
      default: load_data = drdata;
    endcase
  end

  // EX/MEM is frozen while stalled, so the live control bits still describe
  // the op being completed in BUSY.
  assign wb_sel   = memread ? load_data : (movsel ? movresin : aluresin);
  assign complete = (state_q == BUSY) ? dack : (valid & ~is_mem);
  assign stall    = ~rst & ((state_q == IDLE) ? (is_mem & ~misaligned) : ~dack);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // this block leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    dreq_d     = dreq_q;
    dwe_d      = dwe_q;
    daddr_d    = daddr_q;
    dwdata_d   = dwdata_q;
    dsize_d    = dsize_q;
    flags_d    = flags_q;
    fault_d    = 1'b0;
    nop_d      = 1'b1;
    regwrite_d = 1'b0;
    wbdata_d   = wbdata_q;
    rd_d       = rd_q;

    case (state_q)
      IDLE: begin
        if (is_mem && misaligned) begin
          fault_d = 1'b1;
        end else if (is_mem) begin
          daddr_d  = aluresin;
          dwdata_d = readreg2in;
          dsize_d  = size;
          dwe_d    = is_store;
          dreq_d   = 1'b1;
          state_d  = BUSY;
        end
      end
      default: begin
        if (dack) begin
          dreq_d  = 1'b0;
          dwe_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase

    if (complete) begin
      nop_d      = 1'b0;
      regwrite_d = regwrite & ~is_store;
      rd_d       = rdin;
      wbdata_d   = wb_sel;
      if (setflags) flags_d = flagstosetin;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values and evaluation order inside the block cannot matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dreq_q     <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= '0;
      dwdata_q   <= '0;
      dsize_q    <= 2'b00;
      flags_q    <= '0;
      fault_q    <= 1'b0;
      nop_q      <= 1'b1;
      regwrite_q <= 1'b0;
      wbdata_q   <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      dreq_q     <= dreq_d;
      dwe_q      <= dwe_d;
      daddr_q    <= daddr_d;
      dwdata_q   <= dwdata_d;
      dsize_q    <= dsize_d;
      flags_q    <= flags_d;
      fault_q    <= fault_d;
      nop_q      <= nop_d;
      regwrite_q <= regwrite_d;
      wbdata_q   <= wbdata_d;
      rd_q       <= rd_d;
    end
  end

  assign dreq        = dreq_q;
  assign dwe         = dwe_q;
  assign daddr       = daddr_q;
  assign dwdata      = dwdata_q;
  assign dsize       = dsize_q;
  assign flags       = flags_q;
  assign fault       = fault_q;
  assign nopout      = nop_q;
  assign regwriteout = regwrite_q;
  assign wbdata      = wbdata_q;
  assign rdout       = rd_q;

endmodule

// File: tb/tb_memstage.sv
// Scoreboard bench for memstage: a driver pushes expected MEM/WB results, a
// bus responder acknowledges requests, and a monitor pops and compares.
module tb_memstage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nopin, memread, memwrite, setflags, regwrite, movsel, signext;
  logic [1:0]  size;
  logic [63:0] aluresin, movresin, readreg2in, drdata;
  logic [3:0]  flagstosetin;
  logic [4:0]  rdin;
  logic        stall, fault, dreq, dwe, dack, nopout, regwriteout;
  logic [3:0]  flags;
  logic [63:0] daddr, dwdata, wbdata;
  logic [1:0]  dsize;
  logic [4:0]  rdout;

  memstage dut (
    .clk(clk), .rst(rst), .nopin(nopin), .memread(memread), .memwrite(memwrite),
    .setflags(setflags), .regwrite(regwrite), .movsel(movsel), .signext(signext),
    .size(size), .aluresin(aluresin), .movresin(movresin), .readreg2in(readreg2in),
    .flagstosetin(flagstosetin), .rdin(rdin), .stall(stall), .fault(fault),
    .flags(flags), .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dsize(dsize), .dack(dack), .drdata(drdata), .nopout(nopout),
    .regwriteout(regwriteout), .wbdata(wbdata), .rdout(rdout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] alu, mov, rr2, rdata;
    logic [1:0]  size;
    logic        memread, memwrite, setflags, regwrite, movsel, signext;
    logic [3:0]  flg;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    logic [63:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic [3:0]  fl;
    int          bub;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  model_flags = 4'd0;
  int          gap_bubbles = 0;
  int          fault_exp = 0;
  int          fault_seen = 0;
  bit          bus_expected = 1'b0;
  bit          resp_en = 1'b1;
  int          ack_delay = 0;
  int          last_gap = 0;
  logic [63:0] exp_daddr, exp_dwdata;
  logic [1:0]  exp_dsize;
  logic        exp_dwe;
  logic        live;

  // Bubble counting starts only once an edge has been taken out of reset.
  always @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of a load: take 2^size bytes, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] raw, input int nbytes, input bit sx);
    logic [63:0] mask;
    logic [63:0] v;
    int          bits;
    if (nbytes == 8) return raw;
    bits = nbytes * 8;
    mask = (64'd1 << bits) - 64'd1;
    v    = raw & mask;
    if (sx && raw[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic drive(input op_t op);
    nopin        = 1'b0;
    memread      = op.memread;
    memwrite     = op.memwrite;
    setflags     = op.setflags;
    regwrite     = op.regwrite;
    movsel       = op.movsel;
    signext      = op.signext;
    size         = op.size;
    aluresin     = op.alu;
    movresin     = op.mov;
    readreg2in   = op.rr2;
    flagstosetin = op.flg;
    rdin         = op.rd;
    drdata       = op.rdata;
  endtask

  // Called at a negedge; returns at the negedge after the op leaves EX/MEM.
  task automatic issue(input op_t op, input int delay);
    int   nbytes;
    bit   mem, mis, ld, st;
    int   exp_stall;
    int   stall_cnt;
    logic s;
    exp_t e;
    nbytes    = 1 << op.size;
    mem       = op.memread || op.memwrite;
    ld        = op.memread;
    st        = op.memwrite && !op.memread;
    mis       = mem && ((op.alu % 64'(nbytes)) != 64'd0);
    exp_stall = (mem && !mis) ? 1 + delay : 0;
    drive(op);
    if (mis) begin
      fault_exp++;
      gap_bubbles++;
    end else begin
      if (mem) begin
        exp_daddr    = op.alu;
        exp_dwdata   = op.rr2;
        exp_dsize    = op.size;
        exp_dwe      = st;
        ack_delay    = delay;
        bus_expected = 1'b1;
      end
      if (op.setflags) model_flags = op.flg;
      e.wb  = ld ? ref_load(op.rdata, nbytes, op.signext) : (op.movsel ? op.mov : op.alu);
      e.rd  = op.rd;
      e.rw  = op.regwrite && !st;
      e.fl  = model_flags;
      e.bub = gap_bubbles + exp_stall;
      gap_bubbles = 0;
      sb.push_back(e);
    end
    stall_cnt = 0;
    forever begin
      #4;
      s = stall;
      if (s) stall_cnt++;
      @(posedge clk);
      if (!s) break;
      if (stall_cnt > 64) begin
        check("stall_timeout", 64'(stall_cnt), 64'(exp_stall));
        break;
      end
      @(negedge clk);
    end
    bus_expected = 1'b0;
    check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
    @(negedge clk);
  endtask

  task automatic bubble_cycle();
    nopin    = 1'b1;
    memread  = 1'($urandom_range(1));
    memwrite = 1'($urandom_range(1));
    setflags = 1'b1;
    regwrite = 1'b1;
    aluresin = {$urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    gap_bubbles++;
  endtask

  function automatic op_t rand_op(input int kind);
    op_t o;
    int  nbytes;
    o.alu      = {$urandom, $urandom};
    o.mov      = {$urandom, $urandom};
    o.rr2      = {$urandom, $urandom};
    o.rdata    = {$urandom, $urandom};
    o.size     = 2'($urandom_range(3));
    o.setflags = 1'($urandom_range(1));
    o.regwrite = 1'($urandom_range(1));
    o.movsel   = 1'($urandom_range(1));
    o.signext  = 1'($urandom_range(1));
    o.flg      = 4'($urandom_range(15));
    o.rd       = 5'($urandom_range(31));
    o.memread  = (kind == 4 || kind == 5 || kind == 8);
    o.memwrite = (kind == 6 || kind == 7 || kind == 8);
    nbytes     = 1 << o.size;
    if ($urandom_range(3) != 0) o.alu = o.alu & ~(64'(nbytes) - 64'd1);
    return o;
  endfunction

  // Monitor: one sample per cycle, away from the rising edge.
  initial begin
    int   bub;
    exp_t e;
    bub = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        bub = 0;
      end else if (live) begin
        if (fault) begin
          fault_seen++;
          check("fault_bubble", 64'(nopout), 64'd1);
        end
        if (nopout) begin
          bub++;
          check("bubble_regwrite", 64'(regwriteout), 64'd0);
        end else if (sb.size() == 0) begin
          check("unexpected_result", 64'(nopout), 64'd1);
        end else begin
          e = sb.pop_front();
          check("wbdata", wbdata, e.wb);
          check("rdout", 64'(rdout), 64'(e.rd));
          check("regwriteout", 64'(regwriteout), 64'(e.rw));
          check("flags", 64'(flags), 64'(e.fl));
          check("bubbles", 64'(bub), 64'(e.bub));
          bub = 0;
        end
      end
    end
  end

  // Bus responder: checks request stability and acknowledges after ack_delay.
  initial begin
    int   cnt;
    int   low_cnt;
    logic prev;
    cnt = 0; low_cnt = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (resp_en) begin
        if (dreq) begin
          if (!prev) last_gap = low_cnt;
          if (!bus_expected) begin
            check("spurious_dreq", 64'(dreq), 64'd0);
          end else begin
            check("daddr", daddr, exp_daddr);
            check("dwdata", dwdata, exp_dwdata);
            check("dsize", 64'(dsize), 64'(exp_dsize));
            check("dwe", 64'(dwe), 64'(exp_dwe));
          end
          dack = (cnt == ack_delay);
          cnt++;
        end else begin
          low_cnt = prev ? 1 : low_cnt + 1;
          cnt     = 0;
          dack    = 1'($urandom_range(1));
        end
        prev = dreq;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_t o;
    nopin = 1'b0; memread = 1'b1; memwrite = 1'b0; setflags = 1'b0; regwrite = 1'b0;
    movsel = 1'b0; signext = 1'b0; size = 2'b11; aluresin = '0; movresin = '0;
    readreg2in = '0; flagstosetin = '0; rdin = '0; drdata = '0; dack = 1'b0;

    // Reset values, with an aligned load presented so stall is not trivially 0.
    repeat (3) @(negedge clk);
    #1;
    check("rst_dreq", 64'(dreq), 64'd0);
    check("rst_dwe", 64'(dwe), 64'd0);
    check("rst_daddr", daddr, 64'd0);
    check("rst_dwdata", dwdata, 64'd0);
    check("rst_dsize", 64'(dsize), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_nopout", 64'(nopout), 64'd1);
    check("rst_regwriteout", 64'(regwriteout), 64'd0);
    check("rst_wbdata", wbdata, 64'd0);
    check("rst_rdout", 64'(rdout), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADDS: 5 -> x3, flags 0100.
    o = '{default: '0};
    o.alu = 64'd5; o.flg = 4'b0100; o.setflags = 1'b1; o.regwrite = 1'b1; o.rd = 5'd3;
    issue(o, 0);
    check("adds_flags", 64'(flags), 64'h4);
    check("adds_wbdata", wbdata, 64'd5);

    // LDURB 0x1001, sign-extended, ack three cycles late.
    o = '{default: '0};
    o.alu = 64'h1001; o.size = 2'b00; o.memread = 1'b1; o.signext = 1'b1;
    o.regwrite = 1'b1; o.rd = 5'd7; o.rdata = 64'h1234_5678_90AB_CD80;
    issue(o, 3);
    check("ldurb_wbdata", wbdata, 64'hFFFF_FFFF_FFFF_FF80);

    // STUR double at 0x2000.
    o = '{default: '0};
    o.alu = 64'h2000; o.size = 2'b11; o.memwrite = 1'b1; o.regwrite = 1'b1;
    o.rr2 = 64'hDEAD_BEEF; o.rd = 5'd9;
    issue(o, 2);
    check("stur_regwrite", 64'(regwriteout), 64'd0);
    check("stur_nopout", 64'(nopout), 64'd0);

    // Misaligned LDUR double at 0x2004 with setflags: fault, flags untouched.
    o = '{default: '0};
    o.alu = 64'h2004; o.size = 2'b11; o.memread = 1'b1; o.setflags = 1'b1;
    o.flg = 4'hF; o.regwrite = 1'b1; o.rd = 5'd4;
    issue(o, 0);
    check("mis_fault", 64'(fault), 64'd1);
    check("mis_nopout", 64'(nopout), 64'd1);
    check("mis_flags", 64'(flags), 64'h4);
    check("mis_dreq", 64'(dreq), 64'd0);

    // Back-to-back loads acked on their first BUSY cycle.
    o = '{default: '0};
    o.alu = 64'h3008; o.size = 2'b10; o.memread = 1'b1; o.regwrite = 1'b1;
    o.rd = 5'd10; o.rdata = 64'hAAAA_BBBB_8000_0001;
    issue(o, 0);
    o.alu = 64'h3010; o.size = 2'b01; o.signext = 1'b1; o.rd = 5'd11;
    o.rdata = 64'h0000_0000_0000_F00D;
    issue(o, 0);
    check("b2b_dreq_gap", 64'(last_gap), 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(9);
      if (k == 9) bubble_cycle();
      else        issue(rand_op(k), $urandom_range(3));
    end

    // Reset while BUSY with dack low; a later dack must be ignored.
    resp_en = 1'b0;
    dack    = 1'b0;
    o = '{default: '0};
    o.alu = 64'h4000; o.size = 2'b11; o.memread = 1'b1; o.regwrite = 1'b1; o.rd = 5'd5;
    drive(o);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("abort_busy_dreq", 64'(dreq), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_dreq", 64'(dreq), 64'd0);
    check("abort_stall", 64'(stall), 64'd0);
    check("abort_daddr", daddr, 64'd0);
    check("abort_nopout", 64'(nopout), 64'd1);
    check("abort_flags", 64'(flags), 64'd0);
    check("abort_wbdata", wbdata, 64'd0);
    model_flags = 4'd0;
    gap_bubbles = 0;
    @(negedge clk);
    nopin = 1'b1;
    dack  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("late_dack_dreq", 64'(dreq), 64'd0);
    check("late_dack_nopout", 64'(nopout), 64'd1);
    gap_bubbles++;
    @(negedge clk);
    gap_bubbles++;
    dack    = 1'b0;
    resp_en = 1'b1;

    o = '{default: '0};
    o.alu = 64'h77; o.movsel = 1'b1; o.mov = 64'h1234; o.setflags = 1'b1;
    o.flg = 4'b1010; o.regwrite = 1'b1; o.rd = 5'd9;
    issue(o, 0);
    check("recover_wbdata", wbdata, 64'h1234);

    nopin = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("fault_count", 64'(fault_seen), 64'(fault_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
